// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter slice.
//   arb_state_e     : sequencer states (IDLE=0, CALC=1, RESP=2)
//   ArbDefaultWidth : default operand/sum width of the shared adder
//   carry_out/signed_ovf : flag helpers used when ADDER_ARB_FLAGS_EN is defined
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbCalc = 2'd1,
    ArbResp = 2'd2
  } arb_state_e;

  localparam int unsigned ArbDefaultWidth = 16;

  // Unsigned carry-out reconstructed from the operand and sum sign bits.
  function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

  // Two's-complement overflow: like-signed operands producing a sum of the other sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared combinational adder.
//   A, B : operands (WIDTH)
//   sum  : A + B modulo 2^WIDTH (carry discarded)
module adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum
);

  assign sum = A + B;

endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req_i : request vector (NREQ)
//   ptr_i : highest-priority index for this scan (IDW)
//   gnt_o : one-hot grant of the first requester at or after ptr_i, wrapping (NREQ)
//   idx_o : encoded index of the granted requester (IDW)
//   any_o : at least one request present
module adder_arbiter_rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one adder between NREQ requesters.
// One operation in flight at a time: IDLE (grant + capture) -> CALC (register sum)
// -> RESP (hold result until resp_ready).
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake; req_ready is a one-hot pulse in IDLE
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready    : result handshake
//   resp_id, resp_sum   : owner index and registered A+B
//   busy                : state is not IDLE
// Optional: define ADDER_ARB_FLAGS_EN to add resp_carry and resp_ovf outputs.
// NREQ must be 2..8 and 2**IDW >= NREQ.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = ArbDefaultWidth,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_sum,
`ifdef ADDER_ARB_FLAGS_EN
  output logic                  resp_carry,
  output logic                  resp_ovf,
`endif
  output logic                  busy
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
`ifdef ADDER_ARB_FLAGS_EN
  logic             resp_carry_q, resp_carry_d;
  logic             resp_ovf_q, resp_ovf_d;
`endif

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   win_idx;
  logic             any_req;
  logic [WIDTH-1:0] add_sum;

  adder_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A   (op_a_q),
    .B   (op_b_q),
    .sum (add_sum)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
`ifdef ADDER_ARB_FLAGS_EN
    resp_carry_d = resp_carry_q;
    resp_ovf_d   = resp_ovf_q;
`endif
    unique case (state_q)
      ArbIdle: begin
        if (any_req) begin
          op_a_d   = req_a[32'(win_idx) * WIDTH +: WIDTH];
          op_b_d   = req_b[32'(win_idx) * WIDTH +: WIDTH];
          id_d     = win_idx;
          rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          state_d  = ArbCalc;
        end
      end
      ArbCalc: begin
        resp_sum_d   = add_sum;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
`ifdef ADDER_ARB_FLAGS_EN
        resp_carry_d = carry_out(op_a_q[WIDTH-1], op_b_q[WIDTH-1], add_sum[WIDTH-1]);
        resp_ovf_d   = signed_ovf(op_a_q[WIDTH-1], op_b_q[WIDTH-1], add_sum[WIDTH-1]);
`endif
        state_d      = ArbResp;
      end
      ArbResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ArbIdle;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
`ifdef ADDER_ARB_FLAGS_EN
      resp_carry_q <= 1'b0;
      resp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
`ifdef ADDER_ARB_FLAGS_EN
      resp_carry_q <= resp_carry_d;
      resp_ovf_q   <= resp_ovf_d;
`endif
    end
  end

  // A grant seen while rst is high would be dropped by the reset edge, so hide it.
  assign req_ready  = (state_q == ArbIdle && !rst) ? gnt : '0;
  assign busy       = (state_q != ArbIdle);
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
`ifdef ADDER_ARB_FLAGS_EN
  assign resp_carry = resp_carry_q;
  assign resp_ovf   = resp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, directed corner sequences and a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_adder_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  busy;
`ifdef ADDER_ARB_FLAGS_EN
  logic                  resp_carry;
  logic                  resp_ovf;
`endif

  adder_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
`ifdef ADDER_ARB_FLAGS_EN
    .resp_carry (resp_carry),
    .resp_ovf   (resp_ovf),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one outstanding operation, its age in edges, expected result.
  bit               m_have;
  int               m_age;
  int               m_id;
  logic [WIDTH-1:0] m_sum;
  logic             m_carry;
  logic             m_ovf;
  int               m_rr;

  logic [NREQ-1:0]  last_rdy;
  int               last_w;
  int               seen_id1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic raise(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i] = 1'b1;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One clock: entered just after a falling edge with inputs driven, returns after the next
  // falling edge. Compares every observable output against the model.
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    bit              exp_rv;
    int              w;
    logic [16:0]     wide;
    int              ssum;
    #1;
    exp_rdy = '0;
    w = -1;
    if (!rst && !m_have) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr + k) % NREQ;
        if (w < 0 && req_valid[i]) w = i;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    exp_rv = m_have && (m_age >= 2);
    last_rdy = req_ready;
    last_w = w;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(m_have));
    if (resp_valid === 1'b1 && resp_id == IDW'(1)) seen_id1++;
    if (exp_rv) begin
      check("resp_id", 32'(resp_id), 32'(m_id));
      check("resp_sum", 32'(resp_sum), 32'(m_sum));
`ifdef ADDER_ARB_FLAGS_EN
      check("resp_carry", 32'(resp_carry), 32'(m_carry));
      check("resp_ovf", 32'(resp_ovf), 32'(m_ovf));
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_have = 1'b0;
      m_rr   = 0;
    end else if (w >= 0) begin
      wide    = {1'b0, req_a[w*WIDTH +: WIDTH]} + {1'b0, req_b[w*WIDTH +: WIDTH]};
      ssum    = int'($signed(req_a[w*WIDTH +: WIDTH])) + int'($signed(req_b[w*WIDTH +: WIDTH]));
      m_have  = 1'b1;
      m_age   = 1;
      m_id    = w;
      m_sum   = wide[15:0];
      m_carry = wide[16];
      m_ovf   = (ssum > 32767) || (ssum < -32768);
      m_rr    = (w + 1) % NREQ;
    end else if (exp_rv && resp_ready) begin
      m_have = 1'b0;
    end else if (m_have && m_age < 2) begin
      m_age++;
    end
    @(negedge clk);
    if (!rst && w >= 0) req_valid[w] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int c = 0; c < 10 && m_have; c++) cycle();
    check("drain_done", 32'(m_have), 32'd0);
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] exp);
    int c;
    c = 0;
    last_w = -1;
    while (last_w < 0 && c < 12) begin
      cycle();
      c++;
    end
    check(name, 32'(last_rdy), 32'(exp));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ops_a[4];
    logic [15:0] ops_b[4];
    int          exp_order[5];
    int          got;
    logic [NREQ-1:0] rdy_or;

    tbl[0] = '{16'h0021, 16'hF0FF, 0, 16'hF120, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 2, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h1234, 16'h6998, 3, 16'h7BCC, 1'b0, 1'b0};
    tbl[4] = '{16'h7676, 16'h0321, 1, 16'h7997, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 3, 16'h0000, 1'b1, 1'b1};

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_have = 1'b0;
    m_age  = 0;
    m_rr   = 0;
    seen_id1 = 0;

    // Reset values
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_sum", 32'(resp_sum), 32'd0);
    @(negedge clk);

    // Vector table: single requester, fixed latency
    resp_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      raise(tbl[v].id, tbl[v].a, tbl[v].b);
      cycle();
      check("tbl_grant", 32'(last_rdy), 32'(1) << tbl[v].id);
      cycle();
      check("tbl_valid", 32'(resp_valid), 32'd1);
      check("tbl_sum", 32'(resp_sum), 32'(tbl[v].sum));
      check("tbl_id", 32'(resp_id), 32'(tbl[v].id));
`ifdef ADDER_ARB_FLAGS_EN
      check("tbl_carry", 32'(resp_carry), 32'(tbl[v].carry));
      check("tbl_ovf", 32'(resp_ovf), 32'(tbl[v].ovf));
`endif
      cycle();
      check("tbl_idle", 32'(busy), 32'd0);
    end

    // All four requesters permanently requesting: strict rotation from 0
    do_reset();
    ops_a = '{16'h0101, 16'h7676, 16'h4000, 16'hFFF0};
    ops_b = '{16'h0202, 16'h0321, 16'hC000, 16'h0011};
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) raise(i, ops_a[i], ops_b[i]);
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      cycle();
      if (last_w >= 0) begin
        check("rr_order", 32'(last_rdy), 32'(1) << exp_order[got]);
        got++;
      end
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) raise(i, ops_a[i], ops_b[i]);
    end
    check("rr_count", 32'(got), 32'd5);
    req_valid = '0;
    drain();

    // Stalled response with requester 3 waiting
    raise(2, 16'h1234, 16'h6998);
    resp_ready = 1'b0;
    wait_grant("stall_grant", 4'b0100);
    raise(3, 16'h0003, 16'h0004);
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_sum", 32'(resp_sum), 32'h7BCC);
      check("stall_id", 32'(resp_id), 32'd2);
      check("stall_no_grant", 32'(last_rdy), 32'd0);
    end
    resp_ready = 1'b1;
    cycle();
    check("stall_idle", 32'(busy), 32'd0);
    cycle();
    check("stall_next_grant", 32'(last_rdy), 32'b1000);
    drain();

    // Reset during CALC abandons the operation and rewinds the pointer
    raise(1, 16'h0010, 16'h0020);
    wait_grant("pre_grant1", 4'b0010);
    drain();
    raise(2, 16'h0100, 16'h0200);
    wait_grant("pre_grant2", 4'b0100);
    do_reset();
    check("calc_rst_valid", 32'(resp_valid), 32'd0);
    check("calc_rst_busy", 32'(busy), 32'd0);
    check("calc_rst_sum", 32'(resp_sum), 32'd0);
    check("calc_rst_id", 32'(resp_id), 32'd0);
    cycle();
    check("calc_rst_quiet", 32'(resp_valid), 32'd0);
    raise(0, 16'h0001, 16'h0001);
    raise(3, 16'hABCD, 16'h1111);
    cycle();
    check("ptr_after_rst", 32'(last_rdy), 32'b0001);
    drain();
    wait_grant("req3_after_rst", 4'b1000);
    drain();

    // Requester 1 withdraws while 0 is served
    do_reset();
    raise(0, 16'h0500, 16'h0050);
    raise(1, 16'h0600, 16'h0060);
    cycle();
    check("wd_grant0", 32'(last_rdy), 32'b0001);
    req_valid[1] = 1'b0;
    seen_id1 = 0;
    rdy_or = '0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      rdy_or |= last_rdy;
    end
    check("wd_no_ready1", 32'(rdy_or[1]), 32'd0);
    check("wd_no_resp1", 32'(seen_id1), 32'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0) begin
            case ($urandom_range(3))
              0: raise(i, 16'hFFFF, 16'($urandom));
              1: raise(i, 16'h7FFF, 16'($urandom_range(2)));
              default: raise(i, 16'($urandom), 16'($urandom));
            endcase
          end
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(2) != 0);
      cycle();
    end
    req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
